// File: rtl/spi_apb_bridge.sv
// spi_apb_bridge: SPI slave (mode 0, MSB first) acting as an APB initiator.
// A two-byte frame {rw, rsvd, addr} + data performs exactly one APB transfer.
// All SPI pins are oversampled on PCLK; SCK is never used as a clock.
// Optional feature: define SPI_APB_PREADY_EN to let the ACCESS phase wait for PREADY.
module spi_apb_bridge #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              s_sck,
  input  logic              s_ss,
  input  logic              s_mosi,
  output logic              s_miso,
  output logic              s_miso_oe,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_SETUP, RD_ACCESS, DATA, WR_SETUP, WR_ACCESS, HOLD
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                   sck_s, ss_s, mosi_s, sck_q;
  logic                   sck_rise, sck_fall;
  logic [6:0]             rx_sr;
  logic [7:0]             tx_sr;
  logic [7:0]             shift_byte;
  logic [2:0]             bit_cnt;
  logic                   is_write;
  logic                   late;
  logic                   apb_ready;

`ifdef SPI_APB_PREADY_EN
  assign apb_ready = PREADY;
`else
  logic unused_pready;
  assign apb_ready    = 1'b1;
  assign unused_pready = PREADY;
`endif

  // Resynchronise the asynchronous SPI pins; cleared to 0 so a reset mid-frame looks like ss still low
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], s_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], s_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], s_mosi};
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_q;
  assign sck_fall   = ~sck_s & sck_q;
  assign shift_byte = {rx_sr, mosi_s};

  // State register; a reset while ss is still low parks in HOLD so the rest of that frame is discarded
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= ss_s ? IDLE : HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; APB phases always run to completion before ss is looked at
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!ss_s) state_next = CMD;
      CMD: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (sck_rise && bit_cnt == 3'd7) begin
          state_next = shift_byte[7] ? DATA : RD_SETUP;
        end
      end
      RD_SETUP:  state_next = RD_ACCESS;
      RD_ACCESS: if (apb_ready) state_next = ss_s ? IDLE : DATA;
      DATA: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (sck_rise && bit_cnt == 3'd7) begin
          state_next = is_write ? WR_SETUP : HOLD;
        end
      end
      WR_SETUP:  state_next = WR_ACCESS;
      WR_ACCESS: if (apb_ready) state_next = HOLD;
      HOLD:      if (ss_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // APB control strobes decoded straight from the state
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    case (state)
      RD_SETUP:  PSEL = 1'b1;
      RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      WR_SETUP: begin
        PSEL   = 1'b1;
        PWRITE = 1'b1;
      end
      WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift registers, APB address/data, MISO and status flags
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sck_q     <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      is_write  <= 1'b0;
      late      <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      s_miso    <= 1'b0;
      s_miso_oe <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_q     <= sck_s;
      s_miso_oe <= ~ss_s;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx_sr   <= '0;
          late    <= 1'b0;
          s_miso  <= 1'b0;
          if (!ss_s) busy <= 1'b1;
        end
        CMD: begin
          s_miso <= 1'b0;
          if (ss_s) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
          end else if (sck_rise) begin
            rx_sr   <= shift_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              is_write <= shift_byte[7];
              PADDR    <= shift_byte[ADDR_W-1:0];
            end
          end
        end
        RD_SETUP, RD_ACCESS: begin
          s_miso <= 1'b0;
          if (sck_rise) begin
            rx_sr   <= shift_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (sck_fall && !late) begin
            late      <= 1'b1;
            frame_err <= 1'b1;
          end
          if (state == RD_ACCESS && apb_ready) begin
            tx_sr <= (late || sck_fall) ? 8'h00 : PRDATA;
            if (ss_s) busy <= 1'b0;
          end
        end
        DATA: begin
          if (ss_s) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            s_miso    <= 1'b0;
          end else begin
            if (sck_fall) begin
              s_miso <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (sck_rise) begin
              rx_sr   <= shift_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && is_write) PWDATA <= shift_byte;
            end
          end
        end
        HOLD: begin
          s_miso <= 1'b0;
          if (ss_s) busy <= 1'b0;
        end
        default: s_miso <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_bridge.sv
// tb_spi_apb_bridge: directed SPI frames against spi_apb_bridge with an APB monitor/responder.
// Build with SPI_APB_PREADY_EN defined to also exercise the PREADY wait-state frame.
module tb_spi_apb_bridge;

  localparam int HALF = 8;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       s_sck, s_ss, s_mosi;
  logic       s_miso, s_miso_oe;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b1;
  logic       busy, frame_err;

  logic [7:0] rd_val   = 8'h00;
  logic       stall_on = 1'b0;

  int num_checks = 0;
  int num_pass   = 0;

  int psel_cycles = 0, penable_cycles = 0, ferr_cycles = 0, xfer_count = 0, stable_bad = 0;
  int acc_cnt = 0;
  logic       penable_q = 1'b0;
  logic [3:0] setup_addr = '0, last_addr = '0;
  logic       setup_write = 1'b0, last_write = 1'b0;
  logic [7:0] setup_wdata = '0, last_wdata = '0;

  spi_apb_bridge #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s_sck(s_sck), .s_ss(s_ss), .s_mosi(s_mosi),
    .s_miso(s_miso), .s_miso_oe(s_miso_oe),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 PCLK = ~PCLK;

  // APB monitor: counts strobe cycles, checks address/data stability, records each transfer
  always @(negedge PCLK) begin
    if (PSEL) psel_cycles++;
    if (PENABLE) penable_cycles++;
    if (frame_err) ferr_cycles++;
    if (PSEL && !PENABLE) begin
      setup_addr  = PADDR;
      setup_write = PWRITE;
      setup_wdata = PWDATA;
    end
    if (PSEL && PENABLE && (PADDR !== setup_addr || PWRITE !== setup_write || PWDATA !== setup_wdata))
      stable_bad++;
    if (penable_q && !PENABLE) begin
      xfer_count++;
      last_addr  = setup_addr;
      last_write = setup_write;
      last_wdata = setup_wdata;
    end
    penable_q = PENABLE;
  end

  // APB slave model: optional three wait states, read data only valid on the ready cycle
  always @(negedge PCLK) begin
    if (PENABLE) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    if (!stall_on || acc_cnt >= 4) begin
      PREADY = 1'b1;
      PRDATA = rd_val;
    end else begin
      PREADY = 1'b0;
      PRDATA = 8'hEE;
    end
  end

  // Watchdog so a wedged run still ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual === expected) num_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // SPI mode 0 master: MOSI set while SCK low, MISO sampled just before each rise
  task automatic applyStimulus(input logic [31:0] tx_bits, input int nbits, input int rst_bit,
                               output logic [31:0] rx_bits, output logic [1:0] mid_flags);
    rx_bits   = '0;
    mid_flags = '0;
    s_ss      = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
      end
      s_mosi = tx_bits[31-i];
      repeat (HALF) @(negedge PCLK);
      rx_bits[31-i] = s_miso;
      if (i == 4) mid_flags = {busy, s_miso_oe};
      s_sck = 1'b1;
      repeat (HALF) @(negedge PCLK);
      s_sck = 1'b0;
    end
    repeat (HALF) @(negedge PCLK);
    s_ss   = 1'b1;
    s_mosi = 1'b0;
    repeat (12) @(negedge PCLK);
  endtask

  initial begin
    logic [31:0] rx;
    logic [1:0]  mid;
    int p0, e0, f0, x0, s0;

    PRESET = 1'b1;
    s_sck  = 1'b0;
    s_ss   = 1'b1;
    s_mosi = 1'b0;
    repeat (3) @(negedge PCLK);
    checkOutput("reset_ctrl", {25'd0, PSEL, PENABLE, PWRITE, s_miso, s_miso_oe, busy, frame_err}, 32'h0);
    checkOutput("reset_paddr", {28'd0, PADDR}, 32'h0);
    checkOutput("reset_pwdata", {24'd0, PWDATA}, 32'h0);
    PRESET = 1'b0;
    repeat (10) @(negedge PCLK);
    checkOutput("idle_flags", {29'd0, busy, s_miso_oe, PSEL}, 32'h0);

    // Write frame 0x84,0x5A
    p0 = psel_cycles; e0 = penable_cycles; f0 = ferr_cycles; x0 = xfer_count; s0 = stable_bad;
    applyStimulus(32'h845A_0000, 16, -1, rx, mid);
    checkOutput("wr_mid_busy_oe", {30'd0, mid}, 32'h3);
    checkOutput("wr_xfers", xfer_count - x0, 1);
    checkOutput("wr_psel_cyc", psel_cycles - p0, 2);
    checkOutput("wr_penable_cyc", penable_cycles - e0, 1);
    checkOutput("wr_txn", {19'd0, last_write, last_addr, last_wdata}, {19'd0, 1'b1, 4'h4, 8'h5A});
    checkOutput("wr_stable", stable_bad - s0, 0);
    checkOutput("wr_miso", rx, 32'h0);
    checkOutput("wr_ferr", ferr_cycles - f0, 0);
    checkOutput("wr_busy_after", {31'd0, busy}, 32'h0);

    // Read frame 0x08,0x00 returning 0xC3
    rd_val = 8'hC3;
    p0 = psel_cycles; e0 = penable_cycles; f0 = ferr_cycles; x0 = xfer_count;
    applyStimulus(32'h0800_0000, 16, -1, rx, mid);
    checkOutput("rd_xfers", xfer_count - x0, 1);
    checkOutput("rd_psel_cyc", psel_cycles - p0, 2);
    checkOutput("rd_penable_cyc", penable_cycles - e0, 1);
    checkOutput("rd_txn", {27'd0, last_write, last_addr}, {27'd0, 1'b0, 4'h8});
    checkOutput("rd_miso", rx, 32'h00C3_0000);
    checkOutput("rd_ferr", ferr_cycles - f0, 0);

    // Read with the ignored upper CMD bits set: 0x7A reads address 0xA
    rd_val = 8'h5C;
    x0 = xfer_count;
    applyStimulus(32'h7A00_0000, 16, -1, rx, mid);
    checkOutput("rd2_xfers", xfer_count - x0, 1);
    checkOutput("rd2_txn", {27'd0, last_write, last_addr}, {27'd0, 1'b0, 4'hA});
    checkOutput("rd2_miso", rx, 32'h005C_0000);

    // Short write frame: ss released after 5 DATA bits
    p0 = psel_cycles; f0 = ferr_cycles;
    applyStimulus(32'h8577_0000, 13, -1, rx, mid);
    checkOutput("short_psel_cyc", psel_cycles - p0, 0);
    checkOutput("short_ferr", ferr_cycles - f0, 1);
    checkOutput("short_busy", {31'd0, busy}, 32'h0);
    x0 = xfer_count;
    applyStimulus(32'h8321_0000, 16, -1, rx, mid);
    checkOutput("after_short_xfers", xfer_count - x0, 1);
    checkOutput("after_short_txn", {19'd0, last_write, last_addr, last_wdata}, {19'd0, 1'b1, 4'h3, 8'h21});

    // One-cycle reset in the middle of the CMD byte with ss held low
    p0 = psel_cycles; f0 = ferr_cycles;
    applyStimulus(32'h845A_0000, 16, 3, rx, mid);
    checkOutput("rst_mid_busy_oe", {30'd0, mid}, 32'h1);
    checkOutput("rst_psel_cyc", psel_cycles - p0, 0);
    checkOutput("rst_miso", rx, 32'h0);
    checkOutput("rst_ferr", ferr_cycles - f0, 0);
    x0 = xfer_count;
    applyStimulus(32'h8111_0000, 16, -1, rx, mid);
    checkOutput("after_rst_xfers", xfer_count - x0, 1);
    checkOutput("after_rst_txn", {19'd0, last_write, last_addr, last_wdata}, {19'd0, 1'b1, 4'h1, 8'h11});

    // Four-byte frame: only the first two bytes matter
    p0 = psel_cycles; x0 = xfer_count;
    applyStimulus(32'h8233_FFFF, 32, -1, rx, mid);
    checkOutput("long_xfers", xfer_count - x0, 1);
    checkOutput("long_psel_cyc", psel_cycles - p0, 2);
    checkOutput("long_txn", {19'd0, last_write, last_addr, last_wdata}, {19'd0, 1'b1, 4'h2, 8'h33});
    checkOutput("long_miso", rx, 32'h0);

`ifdef SPI_APB_PREADY_EN
    // Read with three wait states; data only valid on the PREADY cycle
    rd_val   = 8'h96;
    stall_on = 1'b1;
    p0 = psel_cycles; e0 = penable_cycles; f0 = ferr_cycles; x0 = xfer_count;
    applyStimulus(32'h0500_0000, 16, -1, rx, mid);
    stall_on = 1'b0;
    checkOutput("stall_xfers", xfer_count - x0, 1);
    checkOutput("stall_penable_cyc", penable_cycles - e0, 4);
    checkOutput("stall_psel_cyc", psel_cycles - p0, 5);
    checkOutput("stall_addr", {28'd0, last_addr}, 32'h5);
    checkOutput("stall_miso", rx, 32'h0096_0000);
    checkOutput("stall_ferr", ferr_cycles - f0, 0);
`endif

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
